mmio_timer: RTL
===============

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port sel, input, 1 bit: bridge chip-select for this device.
REQ-004 SHALL have port addr, input, 32 bits: byte address; only addr[3:2] decoded (00 CTRL, 01 PRESET, 10 COUNT, 11 unmapped).
REQ-005 SHALL have port byteen, input, 4 bits: write byte enables from the memory stage.
REQ-006 SHALL have port wdata, input, 32 bits: write data.
REQ-007 SHALL have port rdata, output, 32 bits: read data.
REQ-008 SHALL have port irq, output, 1 bit: interrupt request to CP0.

Function
REQ-009 SHALL treat a cycle as a write only when sel=1 and byteen=4'b1111; partial byteen and byteen=0 SHALL have no effect.
REQ-010 SHALL return rdata combinationally in the same cycle: CTRL as {28'b0, IM, MODE[1:0], EN}; PRESET; COUNT; 0 for offset 11 or sel=0.
REQ-011 SHALL ignore writes to COUNT and to offset 11.
REQ-012 SHALL apply a CTRL or PRESET write at the next clk edge, clear irq_flag, and force the FSM to IDLE on that edge; the bus write SHALL win over any same-cycle FSM update of that register.
REQ-013 SHALL implement the FSM states IDLE, LOAD, CNT and INT.
REQ-014 IDLE: go to LOAD when EN=1; otherwise stay in IDLE.
REQ-015 LOAD: set COUNT to PRESET, then go to CNT.
REQ-016 CNT: go to IDLE when EN=0, leaving COUNT held.
REQ-017 CNT with EN=1: when COUNT>1, decrement COUNT by 1; otherwise set COUNT=0, set irq_flag, and go to INT.
REQ-018 INT with MODE=00 (one-shot): clear EN, go to IDLE, keep irq_flag set until the next CTRL/PRESET write.
REQ-019 INT with MODE=01 (auto-reload): go to IDLE with EN still set, so reload follows via LOAD; clear irq_flag on leaving INT, making irq a 1-cycle pulse.
REQ-020 SHALL treat MODE values 10 and 11 as 00.
REQ-021 SHALL drive irq = irq_flag & IM as a registered output with no combinational path from bus inputs.
REQ-022 With PRESET=0, SHALL pass IDLE -> LOAD -> CNT -> INT, asserting irq_flag 3 edges after EN is seen in IDLE.
REQ-023 With PRESET=N>=1 and MODE=00, irq_flag SHALL rise N+2 edges after EN is seen in IDLE.
REQ-024 SHALL perform 32-bit unsigned COUNT arithmetic with no wrap below 0.

Reset
REQ-025 On reset_n=0, SHALL asynchronously set CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0 and irq=0.
REQ-026 On reset_n=0 mid-count, SHALL abort immediately and resume only after software sets EN again.

Configuration
REQ-027 With TIMER_AUTORELOAD_EN defined, MODE=01 SHALL behave as in REQ-019.
REQ-028 Without TIMER_AUTORELOAD_EN, MODE=01 SHALL behave as MODE=00 and CTRL[2:1] SHALL read back as 00.

Structure
REQ-029 SHALL take register offsets, state encodings, mode codes and CTRL bit positions from the shared constant.v header.
REQ-030 SHALL consist of a single module with no sub-module.

Verification
REQ-031 SHALL cover one-shot expiry: PRESET=5, CTRL=0x9 -> irq rises 7 edges after EN is seen, stays high, EN reads 0, COUNT reads 0.
REQ-032 SHALL cover auto-reload: PRESET=3, CTRL=0xB -> 1-cycle irq pulses every 6 cycles; COUNT sequence 3,2,1,0 repeats.
REQ-033 SHALL cover masking and clear: PRESET=2, CTRL=0x1 -> irq stays 0 while irq_flag sets; a following CTRL=0x9 write -> irq stays 0 and irq_flag is cleared.
REQ-034 SHALL cover rejected writes: byteen=4'b0011 to PRESET with wdata=0xFFFF, and a full write to COUNT -> both registers unchanged.
REQ-035 SHALL cover async reset: reset_n low for half a cycle at COUNT=7 in CNT -> all registers 0, irq 0, FSM in IDLE.
REQ-036 SHALL cover PRESET=0 with CTRL=0x9 -> irq high 3 edges after EN is seen.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared constants for mmio_timer: register offsets, CTRL bit positions,
// mode codes and FSM state encodings.
package mmio_timer_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'b00;
  localparam logic [1:0] OFF_PRESET = 2'b01;
  localparam logic [1:0] OFF_COUNT  = 2'b10;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT    = 2'b00;
  localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

  localparam logic [3:0] BYTEEN_FULL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } timer_state_e;

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and an IRQ.
// Optional feature macro: TIMER_AUTORELOAD_EN enables MODE=01 auto-reload.
module mmio_timer
  import mmio_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]   ctrl_r;
  logic [31:0]  preset_r;
  logic [31:0]  count_r;
  timer_state_e state_r;
  logic         irq_flag_r;
  logic         irq_r;

  logic [3:0]   ctrl_nxt_s;
  logic [31:0]  preset_nxt_s;
  logic [31:0]  count_nxt_s;
  timer_state_e state_nxt_s;
  logic         irq_flag_nxt_s;

  logic [1:0]   off_s;
  logic         wr_s;
  logic         reg_wr_s;
  logic         en_s;
  logic         reload_s;
  logic         unused_addr_s;

  assign off_s         = addr[3:2];
  assign wr_s          = sel && (byteen == BYTEEN_FULL);
  assign reg_wr_s      = wr_s && ((off_s == OFF_CTRL) || (off_s == OFF_PRESET));
  assign en_s          = ctrl_r[CTRL_EN_BIT];
  assign unused_addr_s = ^{addr[31:4], addr[1:0]};

  // MODE=01 reloads only when the feature is built in; other codes act as one-shot
`ifdef TIMER_AUTORELOAD_EN
  assign reload_s = (ctrl_r[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTORELOAD);
`else
  assign reload_s = 1'b0;
`endif

  // Next-state logic: a CTRL/PRESET bus write overrides the FSM step entirely
  always_comb begin
    ctrl_nxt_s     = ctrl_r;
    preset_nxt_s   = preset_r;
    count_nxt_s    = count_r;
    state_nxt_s    = state_r;
    irq_flag_nxt_s = irq_flag_r;
    if (reg_wr_s) begin
      if (off_s == OFF_CTRL) begin
`ifdef TIMER_AUTORELOAD_EN
        ctrl_nxt_s = wdata[3:0];
`else
        ctrl_nxt_s = {wdata[CTRL_IM_BIT], MODE_ONESHOT, wdata[CTRL_EN_BIT]};
`endif
      end else begin
        preset_nxt_s = wdata;
      end
      irq_flag_nxt_s = 1'b0;
      state_nxt_s    = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en_s) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          count_nxt_s = preset_r;
          state_nxt_s = ST_CNT;
        end
        ST_CNT: begin
          if (!en_s) begin
            state_nxt_s = ST_IDLE;
          end else if (count_r > 32'd1) begin
            count_nxt_s = count_r - 32'd1;
          end else begin
            // Covers COUNT==0 too, so the counter never wraps below zero
            count_nxt_s    = 32'd0;
            irq_flag_nxt_s = 1'b1;
            state_nxt_s    = ST_INT;
          end
        end
        ST_INT: begin
          if (reload_s) begin
            irq_flag_nxt_s = 1'b0;
          end else begin
            ctrl_nxt_s[CTRL_EN_BIT] = 1'b0;
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; irq is registered from the next flag/mask values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r     <= 4'd0;
      preset_r   <= 32'd0;
      count_r    <= 32'd0;
      state_r    <= ST_IDLE;
      irq_flag_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      ctrl_r     <= ctrl_nxt_s;
      preset_r   <= preset_nxt_s;
      count_r    <= count_nxt_s;
      state_r    <= state_nxt_s;
      irq_flag_r <= irq_flag_nxt_s;
      irq_r      <= irq_flag_nxt_s & ctrl_nxt_s[CTRL_IM_BIT];
    end
  end

  // Combinational read mux; deselected or unmapped reads return zero
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (off_s)
        OFF_CTRL:   rdata = {28'd0, ctrl_r};
        OFF_PRESET: rdata = preset_r;
        OFF_COUNT:  rdata = count_r;
        default:    rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  assign irq = irq_r;

endmodule
